// File: rtl/sdrc_pkg.sv
// Shared types and helpers for the SDRAM column-burst sequencer.
// State encoding, colbits codes and the column mask lookup.
package sdrc_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PAGE = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [1:0] COLBITS_8  = 2'b00;
   localparam logic [1:0] COLBITS_9  = 2'b01;
   localparam logic [1:0] COLBITS_10 = 2'b10;
   localparam logic [1:0] COLBITS_11 = 2'b11;

   function automatic logic [11:0] colmask(input logic [1:0] cb);
      logic [11:0] m;
      m = 12'h0ff;
      unique case (cb)
         COLBITS_8:  m = 12'h0ff;
         COLBITS_9:  m = 12'h1ff;
         COLBITS_10: m = 12'h3ff;
         COLBITS_11: m = 12'h7ff;
         default:    m = 12'h0ff;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/sdrc_col_inc.sv
// Column address incrementer for the next-beat path.
// Modulo-2^AW: the carry out of the top bit is dropped.
module sdrc_col_inc #(
   parameter int AW = 12
) (
   input  logic [AW-1:0] a,
   output logic [AW-1:0] y
);

   assign y = a + {{(AW-1){1'b0}}, 1'b1};

endmodule

// File: rtl/sdrc_col_burst_seq.sv
// Column-address sequencer for one SDRAM read/write transfer.
// Steps the column per beat and parks in PAGE on a page wrap.
module sdrc_col_burst_seq #(
   parameter int AW = 12,
   parameter int LW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [1:0]    cfg_colbits,
   input  logic          xfr_req,
   input  logic [AW-1:0] xfr_addr,
   input  logic [LW-1:0] xfr_len,
   input  logic          beat_en,
   input  logic          page_ack,
   input  logic          abort,
   output logic          xfr_ack,
   output logic          busy,
   output logic [AW-1:0] col_addr,
   output logic          last_beat,
   output logic          page_cross,
   output logic          xfr_done,
   output logic          xfr_aborted
);

   import sdrc_pkg::*;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] mask;
   logic [AW-1:0] col_inc;
   logic [AW-1:0] col_nxt;
   logic [LW-1:0] rem;
   logic [LW-1:0] rem_nxt;
   logic          rem_one;
   logic          at_wrap;

   assign mask    = AW'(colmask(cfg_colbits));
   assign rem_one = (rem == LW'(1));
   assign at_wrap = ((col_addr & mask) == mask);

   sdrc_col_inc #(.AW(AW)) u_inc (
      .a (col_addr),
      .y (col_inc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         col_addr <= '0;
         rem      <= '0;
      end else begin
         state    <= state_nxt;
         col_addr <= col_nxt;
         rem      <= rem_nxt;
      end
   end

   // abort outranks beat_en and page_ack
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (xfr_req)
               state_nxt = (xfr_len == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (abort)
               state_nxt = S_IDLE;
            else if (beat_en && rem_one)
               state_nxt = S_DONE;
            else if (beat_en && at_wrap)
               state_nxt = S_PAGE;
         end
         S_PAGE: begin
            if (abort)
               state_nxt = S_IDLE;
            else if (page_ack)
               state_nxt = S_RUN;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      col_nxt = col_addr;
      rem_nxt = rem;
      unique case (state)
         S_IDLE: begin
            if (xfr_req) begin
               col_nxt = xfr_addr & mask;
               rem_nxt = xfr_len;
            end
         end
         S_RUN: begin
            if (abort) begin
               col_nxt = '0;
               rem_nxt = '0;
            end else if (beat_en) begin
               col_nxt = col_inc & mask;
               rem_nxt = rem - LW'(1);
            end
         end
         S_PAGE: begin
            if (abort) begin
               col_nxt = '0;
               rem_nxt = '0;
            end
         end
         default: begin
            col_nxt = col_addr;
            rem_nxt = rem;
         end
      endcase
   end

   always_comb begin
      xfr_ack     = 1'b0;
      busy        = (state != S_IDLE);
      last_beat   = 1'b0;
      page_cross  = 1'b0;
      xfr_done    = 1'b0;
      xfr_aborted = 1'b0;
      unique case (state)
         S_IDLE: xfr_ack = xfr_req & reset_n;
         S_RUN: begin
            last_beat   = rem_one;
            xfr_aborted = abort;
         end
         S_PAGE: begin
            page_cross  = 1'b1;
            xfr_aborted = abort;
         end
         S_DONE:  xfr_done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   a_colbits_static: assert property (
      @(posedge clk) disable iff (!reset_n)
      busy |-> $stable(cfg_colbits)
   ) else $error("cfg_colbits changed while busy");

endmodule

// File: tb/tb_sdrc_col_burst_seq.sv
// Directed, table-driven bench for sdrc_col_burst_seq.
// Inputs change on negedge; outputs are compared 1ns later.
module tb_sdrc_col_burst_seq;

   logic        clk;
   logic        reset_n;
   logic [1:0]  cfg_colbits;
   logic        xfr_req;
   logic [11:0] xfr_addr;
   logic [7:0]  xfr_len;
   logic        beat_en;
   logic        page_ack;
   logic        abort;
   logic        xfr_ack;
   logic        busy;
   logic [11:0] col_addr;
   logic        last_beat;
   logic        page_cross;
   logic        xfr_done;
   logic        xfr_aborted;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        req;
      logic [1:0]  cb;
      logic [11:0] addr;
      logic [7:0]  len;
      logic        beat;
      logic        pack;
      logic        abt;
      logic [17:0] exp;
   } vec_t;

   vec_t tbl[$];

   sdrc_col_burst_seq #(.AW(12), .LW(8)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cfg_colbits (cfg_colbits),
      .xfr_req     (xfr_req),
      .xfr_addr    (xfr_addr),
      .xfr_len     (xfr_len),
      .beat_en     (beat_en),
      .page_ack    (page_ack),
      .abort       (abort),
      .xfr_ack     (xfr_ack),
      .busy        (busy),
      .col_addr    (col_addr),
      .last_beat   (last_beat),
      .page_cross  (page_cross),
      .xfr_done    (xfr_done),
      .xfr_aborted (xfr_aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [17:0] pk(
      input logic ack, input logic bsy, input logic [11:0] col,
      input logic lst, input logic pc, input logic dn, input logic ab);
      return {ack, bsy, col, lst, pc, dn, ab};
   endfunction

   task automatic add(
      input logic req, input logic [1:0] cb, input logic [11:0] addr,
      input logic [7:0] len, input logic beat, input logic pack,
      input logic abt, input logic ack, input logic bsy,
      input logic [11:0] col, input logic lst, input logic pc,
      input logic dn, input logic ab);
      vec_t v;
      v.req  = req;
      v.cb   = cb;
      v.addr = addr;
      v.len  = len;
      v.beat = beat;
      v.pack = pack;
      v.abt  = abt;
      v.exp  = pk(ack, bsy, col, lst, pc, dn, ab);
      tbl.push_back(v);
   endtask

   task automatic drive(
      input logic req, input logic [1:0] cb, input logic [11:0] addr,
      input logic [7:0] len, input logic beat, input logic pack,
      input logic abt);
      xfr_req     = req;
      cfg_colbits = cb;
      xfr_addr    = addr;
      xfr_len     = len;
      beat_en     = beat;
      page_ack    = pack;
      abort       = abt;
   endtask

   task automatic check(input string name, input logic [17:0] exp);
      logic [17:0] got;
      got = pk(xfr_ack, busy, col_addr, last_beat,
               page_cross, xfr_done, xfr_aborted);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got ack/busy/col/last/pc/done/ab=%h required %h",
                  name, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      drive(0, 2'd0, 12'h0, 8'd0, 0, 0, 0);

      // 1: plain 4-beat burst, colbits=10
      add(1,2,12'h010,4,1,0,0, 1,0,12'h000,0,0,0,0);
      add(0,2,0,0,1,0,0, 0,1,12'h010,0,0,0,0);
      add(0,2,0,0,1,0,0, 0,1,12'h011,0,0,0,0);
      add(0,2,0,0,1,0,0, 0,1,12'h012,0,0,0,0);
      add(0,2,0,0,1,0,0, 0,1,12'h013,1,0,0,0);
      add(0,2,0,0,0,0,0, 0,1,12'h014,0,0,1,0);
      add(0,2,0,0,0,0,0, 0,0,12'h014,0,0,0,0);
      // 2: 8-bit page wrap, page_ack held off 5 cycles
      add(1,0,12'h0FE,4,0,0,0, 1,0,12'h014,0,0,0,0);
      add(0,0,0,0,1,0,0, 0,1,12'h0FE,0,0,0,0);
      add(0,0,0,0,1,0,0, 0,1,12'h0FF,0,0,0,0);
      for (int i = 0; i < 5; i++)
         add(0,0,0,0,1,0,0, 0,1,12'h000,0,1,0,0);
      add(0,0,0,0,0,1,0, 0,1,12'h000,0,1,0,0);
      add(0,0,0,0,1,0,0, 0,1,12'h000,0,0,0,0);
      add(0,0,0,0,1,0,0, 0,1,12'h001,1,0,0,0);
      add(0,0,0,0,0,0,0, 0,1,12'h002,0,0,1,0);
      add(0,0,0,0,0,0,0, 0,0,12'h002,0,0,0,0);
      // 3: 11-bit wrap at 0x7FF, no carry into bit 11
      add(1,3,12'h7FF,2,0,0,0, 1,0,12'h002,0,0,0,0);
      add(0,3,0,0,1,0,0, 0,1,12'h7FF,0,0,0,0);
      add(0,3,0,0,0,1,0, 0,1,12'h000,0,1,0,0);
      add(0,3,0,0,1,0,0, 0,1,12'h000,1,0,0,0);
      add(0,3,0,0,0,0,0, 0,1,12'h001,0,0,1,0);
      add(0,3,0,0,0,0,0, 0,0,12'h001,0,0,0,0);
      // 4: null transfer, masked start address; abort in DONE/IDLE ignored
      add(1,0,12'hABC,0,0,0,0, 1,0,12'h001,0,0,0,0);
      add(0,0,0,0,1,1,1, 0,1,12'h0BC,0,0,1,0);
      add(0,0,0,0,0,0,1, 0,0,12'h0BC,0,0,0,0);
      // 6: abort in PAGE with page_ack, req held while busy
      add(1,0,12'h0FF,3,0,0,0, 1,0,12'h0BC,0,0,0,0);
      add(0,0,0,0,1,0,0, 0,1,12'h0FF,0,0,0,0);
      add(1,0,12'h020,1,0,1,1, 0,1,12'h000,0,1,0,1);
      add(1,0,12'h020,1,0,0,0, 1,0,12'h000,0,0,0,0);
      add(0,0,0,0,0,0,0, 0,1,12'h020,1,0,0,0);
      add(0,0,0,0,1,0,1, 0,1,12'h020,1,0,0,1);
      add(0,0,0,0,0,0,0, 0,0,12'h000,0,0,0,0);
      // 5: beat_en duty 1/3, len=3
      add(1,1,12'h130,3,1,0,0, 1,0,12'h000,0,0,0,0);
      add(0,1,0,0,0,0,0, 0,1,12'h130,0,0,0,0);
      add(0,1,0,0,0,0,0, 0,1,12'h130,0,0,0,0);
      add(0,1,0,0,1,0,0, 0,1,12'h130,0,0,0,0);
      add(0,1,0,0,0,0,0, 0,1,12'h131,0,0,0,0);
      add(0,1,0,0,0,0,0, 0,1,12'h131,0,0,0,0);
      add(0,1,0,0,1,0,0, 0,1,12'h131,0,0,0,0);
      add(0,1,0,0,0,0,0, 0,1,12'h132,1,0,0,0);

      #1;
      check("reset", pk(0,0,12'h000,0,0,0,0));
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("post_reset_idle", pk(0,0,12'h000,0,0,0,0));

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i].req, tbl[i].cb, tbl[i].addr, tbl[i].len,
               tbl[i].beat, tbl[i].pack, tbl[i].abt);
         #1;
         check($sformatf("vec%0d", i), tbl[i].exp);
      end

      // async reset mid-RUN: outputs clear before any clock edge
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_mid_run", pk(0,0,12'h000,0,0,0,0));
      @(posedge clk);
      #1;
      check("reset_held", pk(0,0,12'h000,0,0,0,0));
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("idle_after_reset", pk(0,0,12'h000,0,0,0,0));

      // single beat at the 9-bit page edge: done wins over page wrap
      @(negedge clk);
      drive(1, 2'd1, 12'h3FF, 8'd1, 0, 0, 0);
      #1;
      check("ack_after_reset", pk(1,0,12'h000,0,0,0,0));
      @(negedge clk);
      drive(0, 2'd1, 12'h0, 8'd0, 1, 0, 0);
      #1;
      check("last_at_edge", pk(0,1,12'h1FF,1,0,0,0));
      @(negedge clk);
      drive(0, 2'd1, 12'h0, 8'd0, 0, 0, 0);
      #1;
      check("done_not_page", pk(0,1,12'h000,0,0,1,0));
      @(negedge clk);
      #1;
      check("final_idle", pk(0,0,12'h000,0,0,0,0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
